// File: rtl/apb_rr_master_arbiter_if.sv
// Bundle of requester-side and APB-side signals of the round-robin APB master arbiter.
// Requester handshake: a requester raises req with its write/addr/wdata fields and holds
// them stable until the one-cycle done pulse; gnt shows the owner while the transfer runs.
interface apb_rr_master_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [2:0]         Pselx;
    logic [AW-1:0]      Paddr;
    logic [DW-1:0]      Pwdata;
    logic               Pwrite;
    logic               Penable;
    logic [DW-1:0]      Prdata;
    logic               Pready;

    modport master (
        input  req, req_write, req_addr, req_wdata, Prdata, Pready,
        output gnt, done, err, rdata, Pselx, Paddr, Pwdata, Pwrite, Penable
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, Prdata, Pready,
        input  gnt, done, err, rdata, Pselx, Paddr, Pwdata, Pwrite, Penable
    );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters, with
// three-slave address decode, Pready wait states and a watchdog abort.
module apb_rr_master_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    Hclk,
    input  logic                    Hreset,
    apb_rr_master_arbiter_if.master bus,
    output logic [1:0]              state_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam logic [AW-1:0] S0_LO = AW'(32'h8000_0000);
    localparam logic [AW-1:0] S0_HI = AW'(32'h83FF_FFFF);
    localparam logic [AW-1:0] S1_LO = AW'(32'h8400_0000);
    localparam logic [AW-1:0] S1_HI = AW'(32'h87FF_FFFF);
    localparam logic [AW-1:0] S2_LO = AW'(32'h8800_0000);
    localparam logic [AW-1:0] S2_HI = AW'(32'h8BFF_FFFF);

    logic [1:0]      state_q,   state_d;
    logic [PW-1:0]   ptr_q,     ptr_d;
    logic [PW-1:0]   owner_q,   owner_d;
    logic [NREQ-1:0] gnt_q,     gnt_d;
    logic [NREQ-1:0] done_q,    done_d;
    logic            err_q,     err_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic [2:0]      psel_q,    psel_d;
    logic [AW-1:0]   paddr_q,   paddr_d;
    logic [DW-1:0]   pwdata_q,  pwdata_d;
    logic            pwrite_q,  pwrite_d;
    logic            penable_q, penable_d;
    logic [WW-1:0]   wait_q,    wait_d;

    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_write;
    logic [2:0]      sel_psel;
    logic [PW-1:0]   next_ptr;

    function automatic logic [2:0] decode(input logic [AW-1:0] a);
        logic [2:0] s;
        s = 3'b000;
        if (a >= S0_LO && a <= S0_HI) s = 3'b001;
        else if (a >= S1_LO && a <= S1_HI) s = 3'b010;
        else if (a >= S2_LO && a <= S2_HI) s = 3'b100;
        return s;
    endfunction

    // First pending requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
                sel_found = 1'b1;
                sel_idx   = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign sel_addr  = bus.req_addr[sel_idx*AW +: AW];
    assign sel_wdata = bus.req_wdata[sel_idx*DW +: DW];
    assign sel_write = bus.req_write[sel_idx];
    assign sel_psel  = decode(sel_addr);
    assign next_ptr  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        psel_d    = psel_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        wait_d    = wait_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    owner_d  = sel_idx;
                    gnt_d    = NREQ'(1) << sel_idx;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wdata;
                    pwrite_d = sel_write;
                    psel_d   = sel_psel;
                    state_d  = (sel_psel != 3'b000) ? SETUP : ERR;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Success and watchdog abort share the same wind-down; only err and rdata differ.
                if (bus.Pready || wait_q == WW'(TIMEOUT - 1)) begin
                    done_d    = gnt_q;
                    err_d     = !bus.Pready;
                    gnt_d     = '0;
                    psel_d    = 3'b000;
                    penable_d = 1'b0;
                    ptr_d     = next_ptr;
                    state_d   = IDLE;
                    if (bus.Pready && !pwrite_q) rdata_d = bus.Prdata;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                done_d  = gnt_q;
                err_d   = 1'b1;
                gnt_d   = '0;
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 3'b000;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            wait_q    <= wait_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.Pselx   = psel_q;
    assign bus.Paddr   = paddr_q;
    assign bus.Pwdata  = pwdata_q;
    assign bus.Pwrite  = pwrite_q;
    assign bus.Penable = penable_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed scenarios then randomized traffic, all checked
// against a transaction-level model of arbitration order, address map and latency.
module tb_apb_rr_master_arbiter;
    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic       Hclk = 1'b0;
    logic       Hreset;
    logic [1:0] state_o;

    apb_rr_master_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_rr_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .Hclk    (Hclk),
        .Hreset  (Hreset),
        .bus     (bus.master),
        .state_o (state_o)
    );

    always #5 Hclk = ~Hclk;

    logic [AW-1:0]   m_addr  [NREQ];
    logic [DW-1:0]   m_wdata [NREQ];
    logic            m_write [NREQ];
    logic [DW-1:0]   m_rdata;
    int              m_ptr;
    logic [NREQ-1:0] exp_q[$];
    int              n_cmp;
    int              n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return 0;
    endfunction

    // Three 64 MiB windows starting at 0x8000_0000, one slave per window.
    function automatic logic [2:0] slave_of(input logic [AW-1:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
            return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
        return 3'b000;
    endfunction

    task automatic drive_req(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]  = m_addr[i];
            bus.req_wdata[i*DW +: DW] = m_wdata[i];
            bus.req_write[i]          = m_write[i];
        end
        bus.req = v;
    endtask

    task automatic rand_fields(input int i);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      m_addr[i] = 32'h8C00_0000 + ($urandom_range(0, 1023) * 4);
        else if (r == 1) m_addr[i] = 32'h7FFF_FFF0 + ($urandom_range(0, 3) * 4);
        else             m_addr[i] = 32'h8000_0000 + ($urandom_range(0, 2) << 26) + ($urandom & 32'h03FF_FFFC);
        m_wdata[i] = $urandom;
        m_write[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     64'(bus.gnt), 64'(0));
        check({tag, "_done"},    64'(bus.done), 64'(0));
        check({tag, "_err"},     64'(bus.err), 64'(0));
        check({tag, "_pselx"},   64'(bus.Pselx), 64'(0));
        check({tag, "_penable"}, 64'(bus.Penable), 64'(0));
        check({tag, "_pwrite"},  64'(bus.Pwrite), 64'(0));
        check({tag, "_paddr"},   64'(bus.Paddr), 64'(0));
        check({tag, "_pwdata"},  64'(bus.Pwdata), 64'(0));
        check({tag, "_rdata"},   64'(bus.rdata), 64'(0));
        check({tag, "_state"},   64'(state_o), 64'(0));
    endtask

    // One transfer from arbitration to done; called at a negedge with the DUT idle.
    task automatic run(input logic [NREQ-1:0] v, input int waits, input logic drop,
                       input logic [DW-1:0] prd, output int w);
        int              lat;
        int              c;
        bit              seen;
        bit              fail_xfer;
        logic [2:0]      sel;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] exp_done;
        w         = pick(v, m_ptr);
        oh        = NREQ'(1) << w;
        sel       = slave_of(m_addr[w]);
        fail_xfer = (sel == 3'b000) || (waits >= TIMEOUT);
        lat       = (sel == 3'b000) ? 2 : (waits >= TIMEOUT) ? 2 + TIMEOUT : 3 + waits;
        exp_q.push_back(oh);
        drive_req(v);
        bus.Prdata = prd;
        bus.Pready = 1'b0;
        c    = 0;
        seen = 0;
        while (!seen && c < lat + 4) begin
            @(negedge Hclk);
            c++;
            if (bus.done != '0) begin
                seen = 1;
            end else begin
                check("idle_err", 64'(bus.err), 64'(0));
                check("hold_rdata", 64'(bus.rdata), 64'(m_rdata));
                check("gnt", 64'(bus.gnt), 64'(oh));
                if (sel == 3'b000) begin
                    check("err_pselx", 64'(bus.Pselx), 64'(0));
                    check("err_penable", 64'(bus.Penable), 64'(0));
                end else begin
                    check("pselx", 64'(bus.Pselx), 64'(sel));
                    check("penable", 64'(bus.Penable), 64'(c >= 2));
                    check("paddr", 64'(bus.Paddr), 64'(m_addr[w]));
                    check("pwrite", 64'(bus.Pwrite), 64'(m_write[w]));
                    if (m_write[w]) check("pwdata", 64'(bus.Pwdata), 64'(m_wdata[w]));
                end
                bus.Pready = (waits < TIMEOUT) && (c - 2 >= waits);
                if (drop && c == 2) bus.req = v & ~oh;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        if (seen) begin
            exp_done = exp_q.pop_front();
            if (!fail_xfer && !m_write[w]) m_rdata = prd;
            check("latency", 64'(c), 64'(lat));
            check("done", 64'(bus.done), 64'(exp_done));
            check("err", 64'(bus.err), 64'(fail_xfer));
            check("rdata", 64'(bus.rdata), 64'(m_rdata));
            check("done_pselx", 64'(bus.Pselx), 64'(0));
            check("done_penable", 64'(bus.Penable), 64'(0));
            check("done_gnt", 64'(bus.gnt), 64'(0));
        end else begin
            exp_q.delete();
        end
        m_ptr      = (w + 1) % NREQ;
        bus.Pready = 1'b0;
    endtask

    initial begin
        int              w;
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] fresh;
        int              waits;

        n_cmp  = 0;
        n_fail = 0;
        m_ptr  = 0;
        m_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_write[i] = 1'b0;
        end
        Hreset     = 1'b1;
        bus.Pready = 1'b0;
        bus.Prdata = '0;
        drive_req('0);
        repeat (2) @(negedge Hclk);
        check_reset_outputs("reset");
        Hreset = 1'b0;
        @(negedge Hclk);

        // Zero-wait write from requester 0.
        m_addr[0] = 32'h8000_0010; m_wdata[0] = 32'hDEAD_BEEF; m_write[0] = 1'b1;
        run(3'b001, 0, 1'b0, 32'h0, w);

        // Read with three wait states; requester drops req mid-transfer.
        m_addr[1] = 32'h8400_0004; m_wdata[1] = 32'h0; m_write[1] = 1'b0;
        run(3'b010, 3, 1'b1, 32'h1234_5678, w);

        // Unmapped address.
        m_addr[2] = 32'h9000_0000; m_wdata[2] = 32'h5555_AAAA; m_write[2] = 1'b1;
        run(3'b100, 0, 1'b0, 32'h0, w);

        // All three requesting continuously.
        m_addr[0] = 32'h8800_0100; m_write[0] = 1'b0;
        m_addr[1] = 32'h8000_0200; m_write[1] = 1'b1; m_wdata[1] = 32'hCAFE_0001;
        m_addr[2] = 32'h87FF_FFFC; m_write[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run(3'b111, 0, 1'b0, $urandom, w);
            check("rr_order", 64'(w), 64'(k % NREQ));
        end

        // Watchdog: one less than the limit completes, the limit aborts.
        m_addr[0] = 32'h8BFF_FFF0; m_write[0] = 1'b0;
        run(3'b001, TIMEOUT - 1, 1'b0, 32'hA5A5_0F0F, w);
        run(3'b001, TIMEOUT, 1'b0, 32'h0BAD_0BAD, w);

        // Reset in the middle of an ACCESS phase owned by requester 1.
        m_addr[1] = 32'h8400_0040; m_write[1] = 1'b1; m_wdata[1] = 32'h1111_2222;
        drive_req(3'b010);
        repeat (2) @(negedge Hclk);
        check("pre_reset_penable", 64'(bus.Penable), 64'(1));
        Hreset = 1'b1;
        @(negedge Hclk);
        check_reset_outputs("midreset");
        Hreset  = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
        m_addr[0] = 32'h8000_0080; m_write[0] = 1'b0;
        run(3'b011, 1, 1'b0, 32'h7777_8888, w);
        check("post_reset_winner", 64'(w), 64'(0));

        // Randomized traffic with requesters joining while others wait.
        pend = 3'b011;
        for (int i = 0; i < NREQ; i++) rand_fields(i);
        for (int it = 0; it < 40; it++) begin
            waits = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4);
            run(pend, waits, 1'b0, $urandom, w);
            pend  = pend & ~(NREQ'(1) << w);
            fresh = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pend;
            if ((pend | fresh) == '0) fresh = NREQ'(1) << $urandom_range(0, NREQ - 1);
            for (int i = 0; i < NREQ; i++) if (fresh[i]) rand_fields(i);
            pend = pend | fresh;
        end
        drive_req('0);
        @(negedge Hclk);
        check("final_gnt", 64'(bus.gnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
